// File: rtl/rst_seq_pkg.sv
// Shared types, parameter limits and width helper for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } rst_seq_state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int NUM_CH_MIN      = 1;
  localparam int NUM_CH_MAX      = 8;
  localparam int STRETCH_CYC_MIN = 1;
  localparam int STRETCH_CYC_MAX = 65535;
  localparam int GAP_CYC_MIN     = 1;
  localparam int GAP_CYC_MAX     = 255;

  function automatic int rst_seq_cnt_width(input int stretch_cyc, input int gap_cyc);
    int max_v;
    max_v = (stretch_cyc > gap_cyc) ? stretch_cyc : gap_cyc;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Asynchronous-assert, synchronous-deassert reset synchroniser.
module rst_sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic sync_n_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_n_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sync_sequencer.sv
// Reset synchroniser + sequencer: stretches reset, then releases channels in order.
// Optional RST_SEQ_CNT_EN adds a saturating software-reset request counter.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_HOLD    | all channels asserted, waiting for sync release and !sw_rst
// ST_STRETCH | all channels asserted, counting down STRETCH_CYC cycles
// ST_RELEASE | releasing one channel every GAP_CYC cycles, ch0 first
// ST_DONE    | all channels released, sequence complete
module reset_sync_sequencer
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_CH      = 4,
  parameter int STRETCH_CYC = 16,
  parameter int GAP_CYC     = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              sw_rst_i,
  output logic [NUM_CH-1:0] rst_n_o,
`ifdef RST_SEQ_CNT_EN
  output logic [7:0]        sw_rst_cnt_o,
`endif
  output logic              done_o,
  output logic              busy_o
);

  localparam int CW = rst_seq_cnt_width(STRETCH_CYC, GAP_CYC);
  localparam int IW = $clog2(NUM_CH) + 1;

  localparam logic [CW-1:0] STRETCH_LOAD = CW'(STRETCH_CYC - 1);
  localparam logic [CW-1:0] GAP_LOAD     = CW'(GAP_CYC - 1);
  localparam logic [IW-1:0] LAST_CH      = IW'(NUM_CH - 1);

  generate
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
      $error("SYNC_STAGES out of range");
    end
    if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
      $error("NUM_CH out of range");
    end
    if (STRETCH_CYC < STRETCH_CYC_MIN || STRETCH_CYC > STRETCH_CYC_MAX) begin : g_bad_stretch
      $error("STRETCH_CYC out of range");
    end
    if (GAP_CYC < GAP_CYC_MIN || GAP_CYC > GAP_CYC_MAX) begin : g_bad_gap
      $error("GAP_CYC out of range");
    end
  endgenerate

  logic           sync_n;
  rst_seq_state_e state_q;
  logic [CW-1:0]  cnt_q;
  logic [IW-1:0]  ch_idx_q;
  logic [NUM_CH-1:0] rst_n_q;
  logic           done_q;
  logic           busy_q;

  rst_sync_chain #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .sync_n_o (sync_n)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_HOLD;
      cnt_q    <= '0;
      ch_idx_q <= '0;
      rst_n_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else if (sw_rst_i) begin
      state_q  <= ST_HOLD;
      cnt_q    <= '0;
      ch_idx_q <= '0;
      rst_n_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (sync_n) begin
            state_q <= ST_STRETCH;
            cnt_q   <= STRETCH_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_STRETCH: begin
          if (cnt_q == '0) begin
            state_q  <= ST_RELEASE;
            rst_n_q  <= NUM_CH'(1);
            ch_idx_q <= '0;
            cnt_q    <= GAP_LOAD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q == '0) begin
            if (ch_idx_q < LAST_CH) begin
              ch_idx_q <= ch_idx_q + IW'(1);
              // Channels release strictly in order, so shifting a 1 in sets the next bit.
              rst_n_q  <= NUM_CH'({rst_n_q, 1'b1});
              cnt_q    <= GAP_LOAD;
            end else begin
              state_q <= ST_DONE;
              rst_n_q <= '1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          rst_n_q <= '1;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rst_n_o = rst_n_q;
  assign done_o  = done_q;
  assign busy_o  = busy_q;

`ifdef RST_SEQ_CNT_EN
  logic       sw_rst_q;
  logic [7:0] sw_rst_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sw_rst_q     <= 1'b0;
      sw_rst_cnt_q <= '0;
    end else begin
      sw_rst_q <= sw_rst_i;
      if (sw_rst_i && !sw_rst_q && (sw_rst_cnt_q != 8'hFF)) begin
        sw_rst_cnt_q <= sw_rst_cnt_q + 8'd1;
      end
    end
  end

  assign sw_rst_cnt_o = sw_rst_cnt_q;
`endif

endmodule

// File: tb/tb_reset_sync_sequencer.sv
// Directed self-checking bench for reset_sync_sequencer (default and minimal configs).
module tb_reset_sync_sequencer;

  logic       clk;
  logic       rst_n;
  logic       sw_rst;
  logic       sw_rst2;
  logic [3:0] rst_n_o;
  logic       done_o;
  logic       busy_o;
  logic [0:0] rst_n_o2;
  logic       done_o2;
  logic       busy_o2;
`ifdef RST_SEQ_CNT_EN
  logic [7:0] cnt_o;
  logic [7:0] cnt_o2;
`endif

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reset_sync_sequencer #(
    .SYNC_STAGES (2), .NUM_CH (4), .STRETCH_CYC (16), .GAP_CYC (4)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .sw_rst_i (sw_rst),
    .rst_n_o  (rst_n_o),
`ifdef RST_SEQ_CNT_EN
    .sw_rst_cnt_o (cnt_o),
`endif
    .done_o   (done_o),
    .busy_o   (busy_o)
  );

  reset_sync_sequencer #(
    .SYNC_STAGES (3), .NUM_CH (1), .STRETCH_CYC (1), .GAP_CYC (1)
  ) dut2 (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .sw_rst_i (sw_rst2),
    .rst_n_o  (rst_n_o2),
`ifdef RST_SEQ_CNT_EN
    .sw_rst_cnt_o (cnt_o2),
`endif
    .done_o   (done_o2),
    .busy_o   (busy_o2)
  );

  // Edge e counts rising edges after the release event; offset shifts the
  // default timeline for restarts that skip the synchroniser (sw_rst release).
  task automatic check_sequence(input string tag, input int offset, input int n_edges, input bit chk2);
    logic [3:0] exp_r;
    logic       exp_d, exp_b;
    logic       exp_r2, exp_d2, exp_b2;
    for (int e = 1; e <= n_edges; e++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) exp_r[i] = (e >= 19 + 4*i - offset);
      exp_d = (e >= 35 - offset);
      exp_b = (e >= 3 - offset) && (e <= 34 - offset);
      checks++;
      if (rst_n_o !== exp_r) begin
        errors++;
        $display("FAIL %s rst_n_o edge %0d: got %b expected %b", tag, e, rst_n_o, exp_r);
      end
      checks++;
      if (done_o !== exp_d) begin
        errors++;
        $display("FAIL %s done_o edge %0d: got %b expected %b", tag, e, done_o, exp_d);
      end
      checks++;
      if (busy_o !== exp_b) begin
        errors++;
        $display("FAIL %s busy_o edge %0d: got %b expected %b", tag, e, busy_o, exp_b);
      end
      if (chk2) begin
        exp_r2 = (e >= 5);
        exp_d2 = (e >= 6);
        exp_b2 = (e >= 4) && (e <= 5);
        checks++;
        if ({rst_n_o2, done_o2, busy_o2} !== {exp_r2, exp_d2, exp_b2}) begin
          errors++;
          $display("FAIL %s min_cfg edge %0d: got r/d/b %b%b%b expected %b%b%b",
                   tag, e, rst_n_o2, done_o2, busy_o2, exp_r2, exp_d2, exp_b2);
        end
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({rst_n_o, done_o, busy_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state: got r=%b d=%b b=%b expected all 0", rst_n_o, done_o, busy_o);
    end
    checks++;
    if ({rst_n_o2, done_o2, busy_o2} !== 3'b0) begin
      errors++;
      $display("FAIL reset_state_min: got %b%b%b expected 000", rst_n_o2, done_o2, busy_o2);
    end
  endtask

  task automatic test_power_on();
    @(negedge clk) rst_n = 1'b1;
    check_sequence("power_on", 0, 36, 1'b1);
  endtask

  task automatic test_sw_rst_done();
    @(negedge clk) sw_rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({rst_n_o, done_o, busy_o} !== 6'b0) begin
        errors++;
        $display("FAIL sw_rst_hold cycle %0d: got r=%b d=%b b=%b expected all 0", k, rst_n_o, done_o, busy_o);
      end
    end
    @(negedge clk) sw_rst = 1'b0;
    check_sequence("sw_rst_done", 2, 36, 1'b0);
  endtask

  task automatic test_sw_across_rst();
    @(negedge clk);
    rst_n  = 1'b0;
    sw_rst = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({rst_n_o, done_o, busy_o} !== 6'b0) begin
        errors++;
        $display("FAIL sw_across_rst edge %0d: got r=%b d=%b b=%b expected all 0", k, rst_n_o, done_o, busy_o);
      end
    end
    @(negedge clk) sw_rst = 1'b0;
    check_sequence("sw_across_rst", 2, 36, 1'b0);
  endtask

  task automatic test_async_mid();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    check_sequence("pre_mid", 0, 25, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rst_n_o, done_o, busy_o} !== 6'b0) begin
      errors++;
      $display("FAIL async_mid: got r=%b d=%b b=%b expected all 0", rst_n_o, done_o, busy_o);
    end
    @(negedge clk) rst_n = 1'b1;
    check_sequence("post_mid", 0, 36, 1'b0);
  endtask

`ifdef RST_SEQ_CNT_EN
  task automatic test_sw_rst_cnt();
    @(negedge clk) rst_n = 1'b0;
    #1;
    checks++;
    if (cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL cnt_clear: got %0d expected 0", cnt_o);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int p = 1; p <= 300; p++) begin
      @(negedge clk) sw_rst = 1'b1;
      @(negedge clk) sw_rst = 1'b0;
      if (p == 1 || p == 200) begin
        checks++;
        if (cnt_o !== 8'(p)) begin
          errors++;
          $display("FAIL cnt_pulse %0d: got %0d expected %0d", p, cnt_o, p);
        end
      end
    end
    checks++;
    if (cnt_o !== 8'd255) begin
      errors++;
      $display("FAIL cnt_saturate: got %0d expected 255", cnt_o);
    end
    @(negedge clk) rst_n = 1'b0;
    #1;
    checks++;
    if (cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL cnt_after_rst: got %0d expected 0", cnt_o);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask
`endif

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    sw_rst  = 1'b0;
    sw_rst2 = 1'b0;
    test_reset();
    test_power_on();
    test_sw_rst_done();
    test_sw_across_rst();
    test_async_mid();
`ifdef RST_SEQ_CNT_EN
    test_sw_rst_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
